mul_tc_16x16: RTL and testbench



---
 rtl/mul_tc_16x16.sv | 167 ++++++++++++++++
 tb/tb_mul_tc_16x16.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mul_tc_16x16.sv
// Signed 16x16 -> 32 multiplier: radix-4 Booth rows, 3:2 carry-save tree, Kogge-Stone final adder.
// Define MUL_TC_PIPE_EN to register the product (1-cycle latency, sync active-high rst to 0).

module csa32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] z,
    output logic [31:0] s,
    output logic [31:0] c
);
    // The majority out of bit 31 would land at bit 32, which the mod-2^32 result drops.
    logic [30:0] maj;

    assign s   = x ^ y ^ z;
    assign maj = (x[30:0] & y[30:0]) | (x[30:0] & z[30:0]) | (y[30:0] & z[30:0]);
    assign c   = {maj, 1'b0};
endmodule

module mul_tc_16x16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] product
);
    // Sum over rows of -2^(16+2i): the constant half of the sign-extension trick.
    localparam logic [31:0] SIGN_CONST = 32'hAAAB_0000;

    genvar gi, gl;

    logic [16:0]      a_ext;
    logic [16:0]      a_dbl;
    logic [16:0]      b_ext;
    logic [7:0]       neg_vec;
    logic [8:0][31:0] pp_row;
    logic [31:0]      corr_row;

    assign a_ext = {a[15], a};
    assign a_dbl = {a, 1'b0};
    assign b_ext = {b, 1'b0};

    generate
        for (gi = 0; gi < 8; gi++) begin : g_booth
            logic [2:0]  grp;
            logic        sel_one;
            logic        sel_two;
            logic [16:0] mult;
            logic [16:0] pp;

            assign grp     = b_ext[2*gi+2 -: 3];
            assign sel_one = grp[1] ^ grp[0];
            assign sel_two = (grp == 3'b011) || (grp == 3'b100);
            // 111 selects zero, so it is kept positive to avoid a spurious all-ones row.
            assign neg_vec[gi] = grp[2] & ~(grp[1] & grp[0]);
            assign mult = sel_one ? a_ext : (sel_two ? a_dbl : 17'd0);
            assign pp   = mult ^ {17{neg_vec[gi]}};
            assign pp_row[gi] = {15'd0, ~pp[16], pp[15:0]} << (2 * gi);
        end
    endgenerate

    // Negation +1 bits sit on even positions 0..14, the sign constant on 16..31: no overlap.
    always_comb begin
        corr_row = SIGN_CONST;
        for (int i = 0; i < 8; i++) begin
            corr_row[2*i] = neg_vec[i];
        end
    end

    assign pp_row[8] = corr_row;

    // Reduction 9 -> 6 -> 4 -> 3 -> 2.
    logic [5:0][31:0] l1_row;
    logic [3:0][31:0] l2_row;
    logic [2:0][31:0] l3_row;
    logic [31:0]      red_s;
    logic [31:0]      red_c;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_l1
            csa32 u_csa (
                .x(pp_row[3*gi]),
                .y(pp_row[3*gi+1]),
                .z(pp_row[3*gi+2]),
                .s(l1_row[2*gi]),
                .c(l1_row[2*gi+1])
            );
        end
        for (gi = 0; gi < 2; gi++) begin : g_l2
            csa32 u_csa (
                .x(l1_row[3*gi]),
                .y(l1_row[3*gi+1]),
                .z(l1_row[3*gi+2]),
                .s(l2_row[2*gi]),
                .c(l2_row[2*gi+1])
            );
        end
    endgenerate

    csa32 u_csa_l3 (
        .x(l2_row[0]),
        .y(l2_row[1]),
        .z(l2_row[2]),
        .s(l3_row[0]),
        .c(l3_row[1])
    );

    assign l3_row[2] = l2_row[3];

    csa32 u_csa_l4 (
        .x(l3_row[0]),
        .y(l3_row[1]),
        .z(l3_row[2]),
        .s(red_s),
        .c(red_c)
    );

    // Kogge-Stone carry network; carry-in is zero so group generate equals carry.
    logic [5:0][31:0] g_lvl;
    logic [4:0][31:0] p_lvl;
    logic [31:0]      sum_final;

    assign g_lvl[0] = red_s & red_c;
    assign p_lvl[0] = red_s ^ red_c;

    generate
        for (gl = 0; gl < 5; gl++) begin : g_ks
            localparam int D = 1 << gl;
            for (gi = 0; gi < 32; gi++) begin : g_bit
                if (gi >= D) begin : g_merge
                    assign g_lvl[gl+1][gi] = g_lvl[gl][gi] | (p_lvl[gl][gi] & g_lvl[gl][gi-D]);
                    if (gl < 4) begin : g_p
                        assign p_lvl[gl+1][gi] = p_lvl[gl][gi] & p_lvl[gl][gi-D];
                    end
                end else begin : g_pass
                    assign g_lvl[gl+1][gi] = g_lvl[gl][gi];
                    if (gl < 4) begin : g_p
                        assign p_lvl[gl+1][gi] = p_lvl[gl][gi];
                    end
                end
            end
        end
    endgenerate

    assign sum_final = p_lvl[0] ^ {g_lvl[5][30:0], 1'b0};

`ifdef MUL_TC_PIPE_EN
    logic [31:0] product_reg;
    logic        unused_sig;

    always_ff @(posedge clk) begin
        if (rst) begin
            product_reg <= '0;
        end else begin
            product_reg <= sum_final;
        end
    end

    assign product    = product_reg;
    assign unused_sig = g_lvl[5][31];
`else
    logic unused_sig;

    assign product    = sum_final;
    assign unused_sig = &{1'b0, clk, rst, g_lvl[5][31]};
`endif

endmodule

// File: tb/tb_mul_tc_16x16.sv
// Directed-vector bench for mul_tc_16x16; covers the combinational build and, with
// MUL_TC_PIPE_EN defined, the registered build including reset and latency sequences.

module tb_mul_tc_16x16;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a   = '0;
    logic [15:0] b   = '0;
    logic [31:0] product;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [17];

    always #5 clk = ~clk;

    mul_tc_16x16 dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .b(b),
        .product(product)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: a=%h b=%h product=%h expected=%h", name, a, b, act, exp);
        end else begin
            $display("ok   %s: a=%h b=%h product=%h", name, a, b, act);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
        logic signed [31:0] p;
        p = $signed(x) * $signed(y);
        return p;
    endfunction

    // Drive operands and wait until the corresponding product is observable.
    task automatic apply(input logic [15:0] x, input logic [15:0] y);
`ifdef MUL_TC_PIPE_EN
        @(negedge clk);
        a = x;
        b = y;
        @(posedge clk);
        #1;
`else
        a = x;
        b = y;
        #2;
`endif
    endtask

    initial begin
        vecs[0]  = '{16'h8000, 16'h8000, 32'h4000_0000};
        vecs[1]  = '{16'h8000, 16'h7FFF, 32'hC000_8000};
        vecs[2]  = '{16'hFFFF, 16'hFFFF, 32'h0000_0001};
        vecs[3]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
        vecs[4]  = '{16'h1234, 16'h0010, 32'h0001_2340};
        vecs[5]  = '{16'h0000, 16'h8000, 32'h0000_0000};
        vecs[6]  = '{16'hFFFE, 16'h0003, 32'hFFFF_FFFA};
        vecs[7]  = '{16'h0003, 16'hFFFB, 32'hFFFF_FFF1};
        vecs[8]  = '{16'h0001, 16'h8000, 32'hFFFF_8000};
        vecs[9]  = '{16'h8000, 16'h0001, 32'hFFFF_8000};
        vecs[10] = '{16'h8000, 16'hFFFF, 32'h0000_8000};
        vecs[11] = '{16'h7FFF, 16'h8000, 32'hC000_8000};
        vecs[12] = '{16'h0005, 16'h0007, 32'h0000_0023};
        vecs[13] = '{16'hFFFF, 16'h0001, 32'hFFFF_FFFF};
        vecs[14] = '{16'h0100, 16'h0100, 32'h0001_0000};
        vecs[15] = '{16'hAAAA, 16'h5555, 32'hE38E_1C72};
        vecs[16] = '{16'h00FF, 16'hFF00, 32'hFFFF_0100};

        // Reset / clock-independence phase.
        @(negedge clk);
        rst = 1'b1;
        a   = 16'h0003;
        b   = 16'hFFFB;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
`ifdef MUL_TC_PIPE_EN
            check("reset_hold", product, 32'h0000_0000);
`else
            check("comb_ignores_rst", product, 32'hFFFF_FFF1);
`endif
        end

`ifdef MUL_TC_PIPE_EN
        // Release at cycle N: value must appear after edge N and not before.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("latency_before_edge", product, 32'h0000_0000);
        @(posedge clk);
        #1;
        check("latency_after_edge", product, 32'hFFFF_FFF1);
`endif

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d", i), product, vecs[i].exp);
        end

        for (int i = 0; i < 200; i++) begin
            logic [15:0] x;
            logic [15:0] y;
            x = 16'($urandom);
            y = 16'($urandom);
            apply(x, y);
            check($sformatf("rand%0d", i), product, model(x, y));
        end

`ifdef MUL_TC_PIPE_EN
        // Mid-stream reset discards the in-flight result, then results resume.
        apply(16'h1234, 16'h0010);
        check("stream_pre", product, 32'h0001_2340);
        @(negedge clk);
        rst = 1'b1;
        a   = 16'h7FFF;
        b   = 16'h7FFF;
        @(posedge clk);
        #1;
        check("midstream_reset", product, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        a   = 16'hFFFE;
        b   = 16'h0003;
        @(posedge clk);
        #1;
        check("resume_after_reset", product, 32'hFFFF_FFFA);
        apply(16'h8000, 16'h8000);
        check("resume_next", product, 32'h4000_0000);
`else
        // Clock edges with rst toggled must not disturb a combinational result.
        a   = 16'h8000;
        b   = 16'h7FFF;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("comb_clk_edge", product, 32'hC000_8000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("comb_rst_edge", product, 32'hC000_8000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
